turn_input_cond: RTL and testbench
==================================

# turn_input_cond

Front-end conditioner for the tail-light sequencer. It takes the three raw switch inputs (left lever, right lever, hazard), synchronizes and debounces each one, and resolves them into the clean, registered `Left`/`Right` request levels that the sequencer samples in its idle state. It also flags an illegal both-levers condition.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed to accept a change; legal range 1..255.
- `CNT_W`, default 8: debounce counter width. Must satisfy `2**CNT_W > DEBOUNCE_CYCLES`.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-low. The block is in reset while `reset` is 0.
- `left_raw`, in, 1: left lever, asynchronous and bouncy.
- `right_raw`, in, 1: right lever, asynchronous and bouncy.
- `hazard_raw`, in, 1: hazard switch, asynchronous and bouncy.
- `Left`, out, 1: registered left request to the sequencer.
- `Right`, out, 1: registered right request to the sequencer.
- `lever_fault`, out, 1: registered flag, high while both debounced levers are high.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer. All flops reset to 0.
- **Debouncer:** one per channel, each a 4-state FSM with counter `cnt`.
  - `LO`: stable = 0. If sync = 1, go to `PEND_HI` with cnt = 1. Otherwise stay.
  - `PEND_HI`: stable = 0.
    - If sync = 0, go to `LO` and clear cnt.
    - Else if cnt == `DEBOUNCE_CYCLES`, go to `HI` and clear cnt.
    - Else cnt++.
  - `HI`: stable = 1. If sync = 0, go to `PEND_LO` with cnt = 1.
  - `PEND_LO`: mirror of `PEND_HI`, ending in `LO`.
  - Special case `DEBOUNCE_CYCLES` = 1: a pending state commits on the cycle after entry.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles returns the FSM to its previous stable state and leaves stable unchanged.
  - Illegal encodings go to `LO`.
- **Resolver:** combinational from stable values l, r, h; its result is registered into the outputs.
  - `lever_fault` = l & r.
  - `Left` = h | (l & ~r).
  - `Right` = h | (r & ~l).
  - Hazard overrides everything. With hazard high, both outputs are 1 regardless of the levers.
  - With l & r and no hazard, both outputs are 0 and `lever_fault` = 1.
- **Simultaneous changes:** channels are independent. Edges arriving on the same cycle resolve on the same output cycle. Outputs never change mid-cycle.
- **Reset:** assertion mid-operation immediately forces all FSMs to `LO`, cnt to 0, synchronizers to 0, and `Left` = `Right` = `lever_fault` = 0. After deassertion, an input held high is accepted with the full latency below.

## Timing
- **Reset values:** `Left` = 0, `Right` = 0, `lever_fault` = 0. All FSMs in `LO`.
- **Acceptance latency:** take a raw input change that is stable from before edge E0.
  - The sync output changes after edge E2.
  - The FSM enters `PEND` at E3 and commits at E(2+`DEBOUNCE_CYCLES`+1).
  - The output register updates at E(3+`DEBOUNCE_CYCLES`+1).
  - Default: the output changes 8 edges after the raw change.
- **Rejection:** a raw pulse whose synchronized width is ≤ `DEBOUNCE_CYCLES` cycles produces no output change.
- **Combinational paths:** none from input to output. All outputs are flop-driven.
- **Handoff:** the downstream sequencer samples `Left`/`Right` every cycle while idle. Holding a lever keeps the request asserted, which repeats the sequence. There is no handshake.

## Structure
- **Shared package `taillight_pkg`:**
  - `debounce_state_t` enum: `LO`, `PEND_HI`, `HI`, `PEND_LO`, 2 bits.
  - `DEBOUNCE_CYCLES_DEFAULT` constant.
  - The existing tail-light output encodings also move here, so that conditioner and sequencer share one package.
- **Sub-module `debounce_ch`:** 2-flop synchronizer plus debounce FSM plus counter. Ports: `clk`, `reset`, `raw`, `stable`. Parameters: `DEBOUNCE_CYCLES`, `CNT_W`. Instantiated 3 times.
- **Top level:** contains only the instances, the resolver, and the output register.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream with all raw inputs at 1 → all outputs go to 0 immediately. After release with inputs still held, `Left` = `Right` = 1 exactly 8 edges later (default params).
- **Left press:** `left_raw` 0→1, held → `Left` rises on edge 8, and `Right` and `lever_fault` stay 0. Release → `Left` falls 8 edges after the release.
- **Bounce rejection:** `right_raw` toggles with high pulses of 1, 2, 3 and 4 cycles separated by 4-cycle lows → `Right` never asserts. A following 6-cycle-plus hold → `Right` asserts.
- **Hazard override:** `left_raw` already accepted, then `hazard_raw` held → `Left` stays 1 and `Right` rises at +8. Hazard released → `Right` falls at +8 and `Left` stays 1.
- **Both levers:** `left_raw` and `right_raw` raised on the same cycle → at edge 8, `lever_fault` = 1 and `Left` = `Right` = 0. Adding hazard → `Left` = `Right` = 1 while `lever_fault` stays 1.
- **Parameter corner:** `DEBOUNCE_CYCLES` = 1 → acceptance in 5 edges, and a 1-cycle glitch is rejected.

Source files
------------

// File: rtl/taillight_pkg.sv
// Shared types and constants for the tail-light conditioner and sequencer.
// Holds debounce FSM encoding, request bundle, resolver function and lamp patterns.
package taillight_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int DEBOUNCE_CNT_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    PEND_HI = 2'd1,
    HI      = 2'd2,
    PEND_LO = 2'd3
  } debounce_state_t;

  // Resolved request bundle handed from the conditioner to the sequencer.
  typedef struct packed {
    logic fault;
    logic left;
    logic right;
  } turn_req_t;

  // Lamp patterns driven by the sequencer, bit order {LC, LB, LA, RA, RB, RC}.
  typedef enum logic [5:0] {
    TL_OFF = 6'b000_000,
    TL_L1  = 6'b001_000,
    TL_L2  = 6'b011_000,
    TL_L3  = 6'b111_000,
    TL_R1  = 6'b000_100,
    TL_R2  = 6'b000_110,
    TL_R3  = 6'b000_111,
    TL_HAZ = 6'b111_111
  } taillight_t;

  // Hazard wins over everything; both levers together cancel and raise the fault.
  function automatic turn_req_t resolve_req(input logic l, input logic r, input logic h);
    turn_req_t req;
    req.fault = l & r;
    req.left  = h | (l & ~r);
    req.right = h | (r & ~l);
    return req;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: 2-flop synchronizer then debounce FSM; stable follows a change
// after DEBOUNCE_CYCLES+1 agreeing synchronized samples; no backpressure, free-running.
module debounce_ch
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  debounce_state_t  r_state;
  debounce_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // cnt holds the number of agreeing samples seen so far in a pending state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LO: begin
        if (r_sync2) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = C_ONE;
        end
      end
      PEND_HI: begin
        if (!r_sync2) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_LIMIT) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      HI: begin
        if (!r_sync2) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = C_ONE;
        end
      end
      PEND_LO: begin
        if (r_sync2) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_LIMIT) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stable = (r_state == HI) || (r_state == PEND_LO);
  end

endmodule

// File: rtl/turn_input_cond.sv
// Conditions left/right/hazard switches into registered Left/Right requests and a lever fault.
// Latency DEBOUNCE_CYCLES+4 edges from a raw change; no handshake, sampled every cycle.
module turn_input_cond
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic hazard_raw,
  output logic Left,
  output logic Right,
  output logic lever_fault
);

  logic      w_left_stable;
  logic      w_right_stable;
  logic      w_hazard_stable;
  turn_req_t w_req;
  turn_req_t r_req;

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_left_ch (
    .clk    (clk),
    .reset  (reset),
    .raw    (left_raw),
    .stable (w_left_stable)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_right_ch (
    .clk    (clk),
    .reset  (reset),
    .raw    (right_raw),
    .stable (w_right_stable)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_hazard_ch (
    .clk    (clk),
    .reset  (reset),
    .raw    (hazard_raw),
    .stable (w_hazard_stable)
  );

  always_comb begin
    w_req = resolve_req(w_left_stable, w_right_stable, w_hazard_stable);
  end

  // All three outputs leave from one register so they always change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req <= '0;
    end else begin
      r_req <= w_req;
    end
  end

  assign Left        = r_req.left;
  assign Right       = r_req.right;
  assign lever_fault = r_req.fault;

endmodule

// File: tb/tb_turn_input_cond.sv
// Bench for turn_input_cond: default and DEBOUNCE_CYCLES=1 instances share stimulus,
// checked every cycle against a run-length reference model plus directed latency checks.
module tb_turn_input_cond;

  localparam int D_A = 4;
  localparam int D_B = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw = 3'b000;

  logic       l0, r0, f0, l1, r1, f1;
  logic [2:0] out0, out1;

  assign out0 = {f0, l0, r0};
  assign out1 = {f1, l1, r1};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  turn_input_cond #(.DEBOUNCE_CYCLES(D_A), .CNT_W(8)) u_dut_a (
    .clk         (clk),
    .reset       (rst_n),
    .left_raw    (raw[0]),
    .right_raw   (raw[1]),
    .hazard_raw  (raw[2]),
    .Left        (l0),
    .Right       (r0),
    .lever_fault (f0)
  );

  turn_input_cond #(.DEBOUNCE_CYCLES(D_B), .CNT_W(8)) u_dut_b (
    .clk         (clk),
    .reset       (rst_n),
    .left_raw    (raw[0]),
    .right_raw   (raw[1]),
    .hazard_raw  (raw[2]),
    .Left        (l1),
    .Right       (r1),
    .lever_fault (f1)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {fault,L,R}=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int dcyc(input int d);
    return (d == 0) ? D_A : D_B;
  endfunction

  // s = {h, r, l}; returns {fault, Left, Right}
  function automatic logic [2:0] expect_out(input logic [2:0] s);
    logic l, r, h;
    l = s[0];
    r = s[1];
    h = s[2];
    return {l & r, h | (l & ~r), h | (r & ~l)};
  endfunction

  // Reference: a debounced level flips once the synchronized input has disagreed
  // with it for D+1 consecutive samples; outputs lag the debounced levels by one edge.
  logic [2:0] m_p1 = 3'b000;
  logic [2:0] m_p2 = 3'b000;
  logic [2:0] m_stab [2] = '{3'b000, 3'b000};
  logic [2:0] m_out  [2] = '{3'b000, 3'b000};
  int         m_run  [2][3] = '{'{0, 0, 0}, '{0, 0, 0}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 <= '0;
      m_p2 <= '0;
      for (int d = 0; d < 2; d++) begin
        m_stab[d] <= '0;
        m_out[d]  <= '0;
        for (int c = 0; c < 3; c++) m_run[d][c] <= 0;
      end
    end else begin
      m_p1 <= raw;
      m_p2 <= m_p1;
      for (int d = 0; d < 2; d++) begin
        m_out[d] <= expect_out(m_stab[d]);
        for (int c = 0; c < 3; c++) begin
          if (m_p2[c] == m_stab[d][c]) begin
            m_run[d][c] <= 0;
          end else if (m_run[d][c] + 1 > dcyc(d)) begin
            m_run[d][c]  <= 0;
            m_stab[d][c] <= ~m_stab[d][c];
          end else begin
            m_run[d][c] <= m_run[d][c] + 1;
          end
        end
      end
    end
  end

  logic mon_r_a = 1'b0;
  logic mon_l_b = 1'b0;
  logic seen_r_a = 1'b0;
  logic seen_l_b = 1'b0;

  always @(negedge clk) begin
    chk("model_d4", out0, m_out[0]);
    chk("model_d1", out1, m_out[1]);
    if (mon_r_a && r0) seen_r_a <= 1'b1;
    if (mon_l_b && l1) seen_l_b <= 1'b1;
  end

  initial begin
    tick(3);
    chk("reset_d4", out0, 3'b000);
    chk("reset_d1", out1, 3'b000);
    rst_n = 1'b1;
    tick(12);

    // left press and release
    raw[0] = 1'b1;
    tick(4);  chk("lpress_d1_e4", out1, 3'b000);
    tick(1);  chk("lpress_d1_e5", out1, 3'b010);
    tick(2);  chk("lpress_d4_e7", out0, 3'b000);
    tick(1);  chk("lpress_d4_e8", out0, 3'b010);
    tick(4);
    raw[0] = 1'b0;
    tick(7);  chk("lrel_d4_e7", out0, 3'b010);
    tick(1);  chk("lrel_d4_e8", out0, 3'b000);
    tick(6);

    // right bounce: pulses of 1..4 cycles must be rejected at D=4
    mon_r_a = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      raw[1] = 1'b1;
      tick(w);
      raw[1] = 1'b0;
      tick(4);
    end
    tick(8);
    mon_r_a = 1'b0;
    chk("bounce_reject_d4", {2'b00, seen_r_a}, 3'b000);
    raw[1] = 1'b1;
    tick(7);  chk("rhold_d4_e7", out0, 3'b000);
    tick(1);  chk("rhold_d4_e8", out0, 3'b001);
    raw[1] = 1'b0;
    tick(12);

    // hazard override with left already accepted
    raw[0] = 1'b1;
    tick(12); chk("haz_pre", out0, 3'b010);
    raw[2] = 1'b1;
    tick(7);  chk("haz_on_e7", out0, 3'b010);
    tick(1);  chk("haz_on_e8", out0, 3'b011);
    raw[2] = 1'b0;
    tick(7);  chk("haz_off_e7", out0, 3'b011);
    tick(1);  chk("haz_off_e8", out0, 3'b010);
    raw = 3'b000;
    tick(12);

    // both levers on the same cycle, then hazard on top
    raw[0] = 1'b1;
    raw[1] = 1'b1;
    tick(7);  chk("both_e7", out0, 3'b000);
    tick(1);  chk("both_e8", out0, 3'b100);
    raw[2] = 1'b1;
    tick(8);  chk("both_haz_e8", out0, 3'b111);
    tick(4);

    // mid-stream reset with every input held high
    rst_n = 1'b0;
    #1;
    chk("rst_now_d4", out0, 3'b000);
    chk("rst_now_d1", out1, 3'b000);
    tick(1);
    chk("rst_hold_d4", out0, 3'b000);
    rst_n = 1'b1;
    tick(4);  chk("rel_d1_e4", out1, 3'b000);
    tick(1);  chk("rel_d1_e5", out1, 3'b111);
    tick(2);  chk("rel_d4_e7", out0, 3'b000);
    tick(1);  chk("rel_d4_e8", out0, 3'b111);
    raw = 3'b000;
    tick(12);

    // single-cycle glitch at D=1 must be rejected
    mon_l_b = 1'b1;
    raw[0] = 1'b1;
    tick(1);
    raw[0] = 1'b0;
    tick(10);
    mon_l_b = 1'b0;
    chk("glitch_reject_d1", {1'b0, seen_l_b, 1'b0}, 3'b000);

    // random switch activity with occasional mid-stream resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick(1 + int'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end
      tick(1);
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
